// File: rtl/apb_reg_slave.sv
// APB register-bank slave: NUM_REGS word registers, read-only ID at word 0,
// configurable wait states, byte strobes and PSLVERR on bad addresses.
module apb_reg_slave #(
  parameter int unsigned     DATA_W      = 32,
  parameter int unsigned     ADDR_W      = 32,
  parameter int unsigned     NUM_REGS    = 8,
  parameter int unsigned     WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE  = 32'hA9B0_0001
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic [ADDR_W-1:0]          paddr_i,
  input  logic                       pwrite_i,
  input  logic [DATA_W-1:0]          pwdata_i,
  input  logic [DATA_W/8-1:0]        pstrb_i,
  output logic [DATA_W-1:0]          prdata_o,
  output logic                       pready_o,
  output logic                       pslverr_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  // Decode uses live inputs during setup (needed when there are no wait
  // states) and the held request afterwards.
  logic [ADDR_W-1:0]   a_addr;
  logic                a_write;
  logic [ADDR_W-1:0]   a_idx_full;
  logic [IDX_W-1:0]    a_idx;
  logic                a_err;
  logic [DATA_W-1:0]   a_rdata;
  logic                enter_resp;

  always_comb begin
    a_addr     = (state_q == ST_IDLE) ? paddr_i  : addr_q;
    a_write    = (state_q == ST_IDLE) ? pwrite_i : write_q;
    a_idx_full = a_addr >> 2;
    a_idx      = a_idx_full[IDX_W-1:0];
    a_err      = (a_addr[1:0] != 2'b00) ||
                 (a_idx_full >= ADDR_W'(NUM_REGS)) ||
                 (a_write && (a_idx_full == '0));
    a_rdata    = (a_idx == '0) ? ID_VALUE : regs_q[a_idx];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    regs_d     = regs_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          addr_d  = paddr_i;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          strb_d  = pstrb_i;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // Commit on the edge closing the response cycle, strobed lanes only.
        if (psel_i && penable_i && write_q && !a_err) begin
          for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (a_idx == IDX_W'(i)) begin
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      pready_d  = 1'b1;
      pslverr_d = a_err;
      prdata_d  = (a_err || a_write) ? '0 : a_rdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;

  assign regs_o[0 +: DATA_W] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Drives three apb_reg_slave instances (0, 1 and 3 wait states) with directed
// and random APB traffic and checks them against a register-map model.
module tb_apb_reg_slave;

  localparam int unsigned NDUT = 3;
  localparam int unsigned WC [NDUT] = '{0, 1, 3};
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk = 1'b0;
  logic        preset_n;
  logic        psel    [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [31:0] paddr   [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic [3:0]  pstrb   [NDUT];
  logic [31:0] prdata  [NDUT];
  logic        pready  [NDUT];
  logic        pslverr [NDUT];
  logic [255:0] regs   [NDUT];

  logic [31:0] m_regs [NDUT][8];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_reg_slave #(.WAIT_CYCLES(WC[g])) u_dut (
      .pclk      (clk),
      .preset_n  (preset_n),
      .psel_i    (psel[g]),
      .penable_i (penable[g]),
      .paddr_i   (paddr[g]),
      .pwrite_i  (pwrite[g]),
      .pwdata_i  (pwdata[g]),
      .pstrb_i   (pstrb[g]),
      .prdata_o  (prdata[g]),
      .pready_o  (pready[g]),
      .pslverr_o (pslverr[g]),
      .regs_o    (regs[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_err(input logic [31:0] addr, input bit wr);
    logic [31:0] idx;
    idx = addr >> 2;
    return (addr[1:0] != 2'b00) || (idx >= 32'd8) || (wr && idx == 32'd0);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < NDUT; d++) begin
      m_regs[d][0] = ID;
      for (int i = 1; i < 8; i++) m_regs[d][i] = '0;
    end
  endtask

  task automatic chk_regs(input int d);
    for (int i = 0; i < 8; i++)
      chk($sformatf("regs_o[%0d] dut%0d", i, d), regs[d][i*32 +: 32], m_regs[d][i]);
  endtask

  task automatic idle_inputs(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = '0;  pwdata[d] = '0;    pstrb[d] = '0;
  endtask

  // Called at a negedge; returns at a negedge with the bus idle, so two
  // consecutive calls produce back-to-back transfers.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input int abort_at);
    int unsigned w;
    bit err, aborted;
    logic [31:0] exp_rd;
    w = WC[d];
    err = m_err(addr, wr);
    exp_rd = (err || wr) ? 32'd0 : m_regs[d][addr[4:2]];
    aborted = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    paddr[d] = $urandom(); pwdata[d] = $urandom(); pstrb[d] = 4'($urandom());
    for (int k = 1; k <= int'(w) + 1; k++) begin
      @(negedge clk);
      if (k < int'(w) + 1) begin
        chk($sformatf("pready early dut%0d k%0d", d, k), 32'(pready[d]), 32'd0);
      end else begin
        chk($sformatf("pready dut%0d", d), 32'(pready[d]), 32'd1);
        chk($sformatf("pslverr dut%0d a=%h", d, addr), 32'(pslverr[d]), 32'(err));
        chk($sformatf("prdata dut%0d a=%h", d, addr), prdata[d], exp_rd);
      end
      if (k == abort_at) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      for (int j = 0; j <= int'(w); j++) begin
        @(negedge clk);
        chk($sformatf("pready after abort dut%0d", d), 32'(pready[d]), 32'd0);
        chk($sformatf("pslverr after abort dut%0d", d), 32'(pslverr[d]), 32'd0);
      end
    end else begin
      if (wr && !err)
        for (int b = 0; b < 4; b++)
          if (strb[b]) m_regs[d][addr[4:2]][8*b +: 8] = data[8*b +: 8];
      @(negedge clk);
      chk($sformatf("pready width dut%0d", d), 32'(pready[d]), 32'd0);
    end
    chk_regs(d);
    idle_inputs(d);
  endtask

  task automatic chk_reset_state();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset pready dut%0d", d), 32'(pready[d]), 32'd0);
      chk($sformatf("reset pslverr dut%0d", d), 32'(pslverr[d]), 32'd0);
      chk($sformatf("reset prdata dut%0d", d), prdata[d], 32'd0);
      chk_regs(d);
    end
  endtask

  initial begin
    preset_n = 1'b0;
    for (int d = 0; d < NDUT; d++) idle_inputs(d);
    model_clear();
    repeat (3) @(negedge clk);
    chk_reset_state();
    preset_n = 1'b1;
    @(negedge clk);

    // Directed sequence on each wait-state variant.
    for (int d = 0; d < NDUT; d++) begin
      xfer(d, 1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0);
      xfer(d, 0, 32'h4, 32'h0, 4'h0, 0);
      xfer(d, 1, 32'h4, 32'h0000_AB00, 4'b0010, 0);
      xfer(d, 0, 32'h4, 32'h0, 4'h0, 0);
      xfer(d, 0, 32'h0, 32'h0, 4'h0, 0);
      xfer(d, 1, 32'h0, 32'h1111_2222, 4'hF, 0);
      xfer(d, 0, 32'h0, 32'h0, 4'h0, 0);
      xfer(d, 0, 32'h20, 32'h0, 4'h0, 0);
      xfer(d, 0, 32'h6, 32'h0, 4'h0, 0);
      xfer(d, 1, 32'h6, 32'hFFFF_FFFF, 4'hF, 0);
      xfer(d, 1, 32'h8, 32'hCAFE_0008, 4'hF, 0);
      xfer(d, 1, 32'hC, 32'hCAFE_000C, 4'hF, 0);
      xfer(d, 1, 32'hC, 32'h5555_5555, 4'h0, 0);
      xfer(d, 0, 32'h8, 32'h0, 4'h0, 0);
      xfer(d, 0, 32'hC, 32'h0, 4'h0, 0);
      @(negedge clk);
    end

    // Abort a 3-wait-state write in its 2nd access cycle, then a normal read.
    xfer(2, 1, 32'h8, 32'h1234_5678, 4'hF, 2);
    xfer(2, 0, 32'h8, 32'h0, 4'h0, 0);

    // penable high while idle must not start a transfer.
    for (int d = 0; d < NDUT; d++) begin
      psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b1;
      paddr[d] = 32'h10; pwdata[d] = 32'hBAD0_BAD0; pstrb[d] = 4'hF;
    end
    repeat (4) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++)
        chk($sformatf("idle penable pready dut%0d", d), 32'(pready[d]), 32'd0);
    end
    for (int d = 0; d < NDUT; d++) begin
      idle_inputs(d);
      chk_regs(d);
    end
    @(negedge clk);

    // Random traffic, occasional aborts and idle gaps.
    for (int n = 0; n < 150; n++) begin
      int d, r, ab;
      logic [31:0] a;
      d = int'($urandom_range(0, NDUT - 1));
      r = int'($urandom_range(0, 11));
      a = (r < 10) ? 32'(r * 4) : 32'($urandom_range(0, 40));
      ab = 0;
      if (WC[d] > 0 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(1, WC[d] + 1));
      xfer(d, 1'($urandom()), a, $urandom(), 4'($urandom()), ab);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset asserted while the 3-wait-state instance is in WAIT.
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h10; pwdata[2] = 32'h7777_7777; pstrb[2] = 4'hF;
    @(posedge clk);
    #1 penable[2] = 1'b1;
    @(negedge clk);
    preset_n = 1'b0;
    model_clear();
    @(negedge clk);
    chk_reset_state();
    preset_n = 1'b1;
    idle_inputs(2);
    @(negedge clk);
    xfer(2, 1, 32'h10, 32'hA5A5_5A5A, 4'hF, 0);
    xfer(2, 0, 32'h10, 32'h0, 4'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
